// File: rtl/shifter32_onehot_pkg.sv
// Shared types and widths for the one-hot driven 32-bit shift unit.
package shifter32_onehot_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
endpackage

// File: rtl/shifter32_onehot_if.sv
// Operand/result bundle between the issue stage and the shift unit.
interface shifter32_onehot_if;
  import shifter32_onehot_pkg::*;

  logic   in_valid;
  word_t  datain;
  shamt_t shamt;
  logic   out_valid;
  word_t  shift_onehot;
  word_t  shiftleft;
  word_t  shiftright;

  modport master (
    output in_valid, datain, shamt,
    input  out_valid, shift_onehot, shiftleft, shiftright
  );

  modport slave (
    input  in_valid, datain, shamt,
    output out_valid, shift_onehot, shiftleft, shiftright
  );
endinterface

// File: rtl/shifter32_onehot_decoder_5to32_onehot.sv
// Shift-amount decoder: every 5-bit code maps to exactly one set bit.
module decoder_5to32_onehot
  import shifter32_onehot_pkg::*;
(
  input  shamt_t shamt,
  output word_t  onehot
);
  for (genvar k = 0; k < DATA_W; k++) begin : g_dec
    assign onehot[k] = (shamt == shamt_t'(k));
  end
endmodule

// File: rtl/shifter32_onehot.sv
// Registered logical shifter: one-hot select feeds AND-OR networks for SLL and SRL.
module shifter32_onehot
  import shifter32_onehot_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  shifter32_onehot_if.slave    bus
);
  if (WIDTH != DATA_W || SHAMT_W != $clog2(WIDTH)) begin : g_bad_cfg
    $error("shifter32_onehot supports only WIDTH=32, SHAMT_W=5");
  end

  word_t onehot;
  word_t left;
  word_t right;

  decoder_5to32_onehot u_dec (
    .shamt  (bus.shamt),
    .onehot (onehot)
  );

  // Output bit j gathers candidate source bits, one per possible shift amount;
  // the one-hot select ensures only one term can be live.
  for (genvar j = 0; j < DATA_W; j++) begin : g_bit
    word_t lterm;
    word_t rterm;
    for (genvar k = 0; k < DATA_W; k++) begin : g_term
      if (k <= j) begin : g_l
        assign lterm[k] = onehot[k] & bus.datain[j-k];
      end else begin : g_lz
        assign lterm[k] = 1'b0;
      end
      if (j + k < DATA_W) begin : g_r
        assign rterm[k] = onehot[k] & bus.datain[j+k];
      end else begin : g_rz
        assign rterm[k] = 1'b0;
      end
    end
    assign left[j]  = |lterm;
    assign right[j] = |rterm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.shiftleft    <= '0;
      bus.shiftright   <= '0;
      bus.shift_onehot <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      // Results hold when idle so the ALU mux sees a stable last value.
      if (bus.in_valid) begin
        bus.shiftleft    <= left;
        bus.shiftright   <= right;
        bus.shift_onehot <= onehot;
      end
    end
  end
endmodule

// File: tb/tb_shifter32_onehot.sv
// Directed and random checks of the shift unit against an arithmetic reference.
module tb_shifter32_onehot;
  import shifter32_onehot_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference state, computed with plain << / >>.
  logic  m_valid;
  word_t m_left, m_right, m_oh;

  shifter32_onehot_if bus ();

  shifter32_onehot dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input word_t d, input shamt_t s);
    logic [31:0] one;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.datain = d;
    bus.shamt = s;
    one = 32'd1;
    if (r) begin
      m_valid = 1'b0; m_left = '0; m_right = '0; m_oh = '0;
    end else begin
      m_valid = v;
      if (v) begin
        m_left  = d << s;
        m_right = d >> s;
        m_oh    = one << s;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    check("shiftleft", bus.shiftleft, m_left);
    check("shiftright", bus.shiftright, m_right);
    check("shift_onehot", bus.shift_onehot, m_oh);
  endtask

  initial begin
    word_t  d;
    shamt_t s;
    logic   v;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.datain = '0;
    bus.shamt = '0;
    m_valid = 1'b0; m_left = '0; m_right = '0; m_oh = '0;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 5'd0);
    step(1'b1, 1'b0, 32'h0, 5'd0);

    // Full sweep of all-ones
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 32'hFFFF_FFFF, shamt_t'(i));
      if (i == 8) begin
        check("sweep8_left", bus.shiftleft, 32'hFFFF_FF00);
        check("sweep8_right", bus.shiftright, 32'h00FF_FFFF);
      end
    end

    // Nibble pattern
    step(1'b0, 1'b1, 32'h1234_5678, 5'd4);
    check("pat_left", bus.shiftleft, 32'h2345_6780);
    check("pat_right", bus.shiftright, 32'h0123_4567);
    check("pat_oh", bus.shift_onehot, 32'h0000_0010);

    // Extremes
    step(1'b0, 1'b1, 32'h8000_0001, 5'd0);
    check("sh0_left", bus.shiftleft, 32'h8000_0001);
    check("sh0_right", bus.shiftright, 32'h8000_0001);
    step(1'b0, 1'b1, 32'h8000_0001, 5'd31);
    check("sh31_left", bus.shiftleft, 32'h8000_0000);
    check("sh31_right", bus.shiftright, 32'h0000_0001);

    // Valid pulse then hold
    step(1'b0, 1'b1, 32'hA5A5_A5A5, 5'd1);
    check("pulse_left", bus.shiftleft, 32'h4B4B_4B4A);
    check("pulse_right", bus.shiftright, 32'h52D2_D2D2);
    step(1'b0, 1'b0, 32'h1111_1111, 5'd7);
    step(1'b0, 1'b0, 32'h2222_2222, 5'd9);
    check("hold_left", bus.shiftleft, 32'h4B4B_4B4A);
    check("hold_right", bus.shiftright, 32'h52D2_D2D2);
    check("hold_valid", {31'b0, bus.out_valid}, 32'h0);

    // Reset wins over a concurrent transaction
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd5);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd3);
    check("rst_left", bus.shiftleft, 32'h0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd3);
    check("post_rst_left", bus.shiftleft, 32'hFFFF_FFF8);
    check("post_rst_right", bus.shiftright, 32'h1FFF_FFFF);

    // Random traffic with occasional idle cycles
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      s = shamt_t'($urandom_range(0, 31));
      v = ($urandom_range(0, 9) != 0);
      step(1'b0, v, d, s);
      if (v) check("rand_popcount", $countones(bus.shift_onehot), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shifter32_onehot.md
Name: shifter32_onehot

Overview:
- Registered 32-bit logical shifter. It produces both a left-shift and a right-shift result of one data word by a 5-bit amount.
- The amount is first decoded into a 32-bit one-hot select. The select drives an AND-OR mux network, not a native shift operator.
- The block sits in the integer datapath as the shift unit feeding SLL/SRL-style results to the ALU result mux.

Parameters:
- WIDTH, 32, data width; fixed at 32. Other values are not supported; elaborate-time error if changed.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies datain/shamt this cycle
- datain  input  32  operand to shift
- shamt  input  5  shift amount, 0..31, unsigned
- out_valid  output  1  results valid; registered
- shift_onehot  output  32  registered one-hot decode of the captured shamt (debug/verification visibility)
- shiftleft  output  32  registered datain << shamt, zero fill
- shiftright  output  32  registered datain >> shamt, logical, zero fill

Behaviour:
- Reset (rst=1 at a rising clk edge): out_valid=0, shiftleft=0, shiftright=0, shift_onehot=0. Reset has priority over in_valid. A transaction presented in the reset cycle is dropped.
- Decode (combinational): onehot[k]=1 iff shamt==k. Exactly one bit is set for every shamt value 0..31. There are no illegal codes.
- Left shift (combinational): left[j] = OR over k of (onehot[k] AND datain[j-k]). Terms with j-k<0 contribute 0.
- Right shift (combinational): right[j] = OR over k of (onehot[k] AND datain[j+k]). Terms with j+k>31 contribute 0. No sign extension.
- Latency is 1 cycle. On a clk edge with rst=0 and in_valid=1, the outputs register as follows:
  - shiftleft <= left
  - shiftright <= right
  - shift_onehot <= onehot
  - out_valid <= 1
- On a clk edge with rst=0 and in_valid=0:
  - out_valid <= 0.
  - shiftleft, shiftright and shift_onehot hold their previous values.
- Throughput: one transaction per cycle. There is no backpressure and no stall input.
- Boundaries:
  - shamt=0 gives both outputs equal to datain.
  - shamt=31 gives shiftleft={datain[0],31'b0} and shiftright={31'b0,datain[31]}.
  - Results never depend on shift amounts ≥32; that range is unrepresentable.
- Back-to-back in_valid: each cycle's result appears exactly one cycle later, with no bubbles.
- Reset asserted mid-stream: the next edge clears all outputs. The in-flight result is lost.

Decomposition:
- Shared package holds:
  - localparam DATA_W=32 and SHAMT_W=5
  - typedef word_t (logic [31:0])
  - typedef shamt_t (logic [4:0])
- One sub-module, decoder_5to32_onehot: purely combinational, shamt_t in, word_t one-hot out.
- The top instantiates the decoder. Top also owns the two AND-OR mux networks (generate loops) and the output registers.

Test Plan:
- Sweep: datain=0xFFFFFFFF, shamt=0..31 with in_valid=1 each cycle. One cycle later, shiftleft==0xFFFFFFFF<<shamt and shiftright==0xFFFFFFFF>>shamt. Example: shamt=8 gives 0xFFFFFF00 / 0x00FFFFFF.
- Pattern: datain=0x12345678, shamt=4 gives shiftleft=0x23456780, shiftright=0x01234567, shift_onehot=0x00000010.
- Extremes:
  - datain=0x80000001, shamt=0 gives both outputs 0x80000001.
  - Same datain, shamt=31 gives shiftleft=0x80000000, shiftright=0x00000001.
- Valid/hold:
  - Pulse in_valid with datain=0xA5A5A5A5, shamt=1. Next cycle out_valid=1, shiftleft=0x4B4B4B4A, shiftright=0x52D2D2D2.
  - Then hold in_valid=0. out_valid drops to 0 and the data outputs hold those values.
- Reset:
  - Apply rst=1 together with in_valid=1 (datain=0xFFFFFFFF, shamt=3). After that edge, all outputs are 0 and out_valid=0.
  - Release rst. The next transaction completes normally.
- Randomized: 1000 random datain/shamt pairs. Check against reference << and >>, and check that shift_onehot has exactly one bit set, at position shamt.
